// File: rtl/usb_rx_phy.sv
// usb_rx_phy: USB full-speed receive PHY.
// Synchronizes D+/D-, recovers bit timing at 4x oversampling, detects SYNC,
// NRZI-decodes, removes stuffed bits and assembles bytes LSB first.
// Optional macro USB_RX_STUFF_CHECK_EN: a 1 in a stuffed-bit slot aborts the
// packet with rx_error; when undefined the stuffed bit is dropped silently.
module usb_rx_phy #(
  parameter int SYNC_STAGES  = 2,  // must be >= 2
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       usb_d_p,
  input  logic       usb_d_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam int CntW = $clog2(SYNC_TIMEOUT + 1);

  typedef enum logic [1:0] {LsSe0 = 2'd0, LsJ = 2'd1, LsK = 2'd2} line_e;
  typedef enum logic [1:0] {StIdle, StSync, StData, StEop} state_e;

  logic [SYNC_STAGES-1:0] r_dp_sync;
  logic [SYNC_STAGES-1:0] r_dn_sync;
  line_e                  w_line;
  line_e                  r_line;
  logic [1:0]             r_phase;
  logic                   w_sample;
  logic                   w_nrzi;

  state_e                 r_state;
  line_e                  r_prev;
  logic [CntW-1:0]        r_sync_cnt;
  logic [2:0]             r_bit_cnt;
  logic [2:0]             r_ones;
  logic [7:0]             r_shift;

  // Input synchronizer; resets to the J (idle) line state.
  always_ff @(posedge clk48) begin
    if (rst) begin
      r_dp_sync <= '1;
      r_dn_sync <= '0;
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], usb_d_p};
      r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], usb_d_n};
    end
  end

  // Line-state decode; SE1 is folded into J.
  always_comb begin
    w_line = LsJ;
    if (!r_dp_sync[SYNC_STAGES-1] && !r_dn_sync[SYNC_STAGES-1]) begin
      w_line = LsSe0;
    end else if (!r_dp_sync[SYNC_STAGES-1] && r_dn_sync[SYNC_STAGES-1]) begin
      w_line = LsK;
    end
  end

  // Phase counter restarts on every line change so samples land mid-bit.
  always_ff @(posedge clk48) begin
    if (rst) begin
      r_line  <= LsJ;
      r_phase <= 2'd0;
    end else begin
      r_line  <= w_line;
      r_phase <= (w_line != r_line) ? 2'd0 : r_phase + 2'd1;
    end
  end

  assign w_sample = (r_phase == 2'd2);
  assign w_nrzi   = (r_line == r_prev);

  // Receive FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk48) begin
    if (rst) begin
      r_state    <= StIdle;
      r_prev     <= LsJ;
      r_sync_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_ones     <= 3'd0;
      r_shift    <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_active  <= 1'b0;
      rx_eop     <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_eop   <= 1'b0;
      rx_error <= 1'b0;
      if (w_sample) begin
        unique case (r_state)
          StIdle: begin
            if (r_line == LsK) begin
              r_state    <= StSync;
              r_prev     <= LsK;
              r_sync_cnt <= '0;
            end
          end
          StSync: begin
            if (r_line == LsSe0) begin
              r_state <= StIdle;
            end else if (r_line == LsK && r_prev == LsK) begin
              // Trailing KK of SYNC; the run-of-ones count starts fresh with data.
              r_state   <= StData;
              r_prev    <= r_line;
              rx_active <= 1'b1;
              r_bit_cnt <= 3'd0;
              r_ones    <= 3'd0;
            end else begin
              r_prev <= r_line;
              if (r_sync_cnt == CntW'(SYNC_TIMEOUT - 1)) begin
                r_state <= StIdle;
              end else begin
                r_sync_cnt <= r_sync_cnt + 1'b1;
              end
            end
          end
          StData: begin
            if (r_line == LsSe0) begin
              r_state   <= StEop;
              r_bit_cnt <= 3'd0;
              if (r_bit_cnt != 3'd0) begin
                rx_error <= 1'b1;
              end
            end else begin
              r_prev <= r_line;
              if (r_ones == 3'd6) begin
                // Stuffed-bit slot: never enters the byte.
                r_ones <= 3'd0;
`ifdef USB_RX_STUFF_CHECK_EN
                if (w_nrzi) begin
                  rx_error  <= 1'b1;
                  rx_active <= 1'b0;
                  r_state   <= StEop;
                  r_bit_cnt <= 3'd0;
                end
`endif
              end else begin
                r_ones  <= w_nrzi ? r_ones + 3'd1 : 3'd0;
                r_shift <= {w_nrzi, r_shift[7:1]};
                if (r_bit_cnt == 3'd7) begin
                  rx_data  <= {w_nrzi, r_shift[7:1]};
                  rx_valid <= 1'b1;
                end
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          StEop: begin
            if (r_line == LsJ) begin
              rx_eop    <= 1'b1;
              rx_active <= 1'b0;
              r_state   <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_phy.sv
// tb_usb_rx_phy: scoreboard bench for usb_rx_phy. Packets are built from byte
// lists, bit-stuffed and NRZI-encoded here; expected events go into a queue
// that an independent monitor drains as the DUT pulses.
module tb_usb_rx_phy;

  localparam logic [1:0] SymJ   = 2'b10;
  localparam logic [1:0] SymK   = 2'b01;
  localparam logic [1:0] SymSe0 = 2'b00;

  localparam int EvValid = 0;
  localparam int EvError = 1;
  localparam int EvEop   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       active;
  } ev_t;

  logic       clk48 = 1'b0;
  logic       rst   = 1'b1;
  logic       usb_d_p = 1'b1;
  logic       usb_d_n = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         per_mode = 0;
  bit         alt = 1'b0;
  logic [7:0] pkt[8];

  usb_rx_phy #(
    .SYNC_STAGES (2),
    .SYNC_TIMEOUT(16)
  ) dut (
    .clk48    (clk48),
    .rst      (rst),
    .usb_d_p  (usb_d_p),
    .usb_d_n  (usb_d_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_active(rx_active),
    .rx_eop   (rx_eop),
    .rx_error (rx_error)
  );

  always #5 clk48 = ~clk48;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ls, input int cycles);
    {usb_d_p, usb_d_n} = ls;
    repeat (cycles) @(negedge clk48);
  endtask

  // One bit time: 4 clocks, or alternating 3/5 clocks.
  task automatic bit_time(input logic [1:0] ls);
    int p;
    if (per_mode == 0) begin
      p = 4;
    end else begin
      alt = ~alt;
      p = alt ? 3 : 5;
    end
    drive(ls, p);
  endtask

  task automatic send_sync();
    logic [1:0] s[8];
    s = '{SymK, SymJ, SymK, SymJ, SymK, SymJ, SymK, SymK};
    alt = 1'b0;
    for (int i = 0; i < 8; i++) bit_time(s[i]);
  endtask

  task automatic push_ev(input int kind, input logic [7:0] data, input logic active);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.active = active;
    exp_q.push_back(e);
  endtask

  // Model: stuff a 0 after every six 1s (optionally corrupting the first stuff
  // slot to a 1), NRZI-encode from the K that ends SYNC, and predict events.
  task automatic send_packet(input int nbytes, input int extra, input bit bad_stuff);
    logic       raw[$];
    logic       line_bits[$];
    int         ones;
    int         sent;
    bit         violated;
    bit         bad_done;
    logic [1:0] lvl;
    for (int i = 0; i < nbytes; i++)
      for (int b = 0; b < 8; b++) raw.push_back(pkt[i][b]);
    for (int i = 0; i < extra; i++) raw.push_back(logic'($urandom_range(0, 1)));
    ones = 0;
    sent = 0;
    violated = 1'b0;
    bad_done = 1'b0;
    for (int i = 0; i < raw.size(); i++) begin
      line_bits.push_back(raw[i]);
      sent++;
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        ones = 0;
        if (bad_stuff && !bad_done) begin
          line_bits.push_back(1'b1);
          bad_done = 1'b1;
`ifdef USB_RX_STUFF_CHECK_EN
          violated = 1'b1;
          break;
`endif
        end else begin
          line_bits.push_back(1'b0);
        end
      end
    end
    for (int k = 0; k < sent / 8; k++) push_ev(EvValid, pkt[k], 1'b1);
    if (violated) push_ev(EvError, 8'h00, 1'b0);
    else if (sent % 8 != 0) push_ev(EvError, 8'h00, 1'b1);
    push_ev(EvEop, 8'h00, 1'b0);

    send_sync();
    lvl = SymK;
    for (int i = 0; i < line_bits.size(); i++) begin
      if (!line_bits[i]) lvl = (lvl == SymK) ? SymJ : SymK;
      bit_time(lvl);
    end
    bit_time(SymSe0);
    bit_time(SymSe0);
    bit_time(SymJ);
    drive(SymJ, 8);
  endtask

  // Bounded wait for every expected event to be seen.
  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk48);
      t++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_active"}, rx_active, 0);
    check({tag, "_rx_eop"}, rx_eop, 0);
    check({tag, "_rx_error"}, rx_error, 0);
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_pulse: got event kind %0d, expected none", kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EvValid) check("rx_data", rx_data, e.data);
      check("rx_active_at_event", rx_active, e.active);
    end
  endtask

  // Monitor: compare every output pulse against the head of the queue.
  initial begin
    forever begin
      @(negedge clk48);
      if (rst) continue;
      if (rx_valid) pop_cmp(EvValid);
      if (rx_error) pop_cmp(EvError);
      if (rx_eop) pop_cmp(EvEop);
    end
  end

  initial begin
    logic [1:0] lvl;
    int         nb;
    int         ex;
    bit         bad;

    // Reset with line idle.
    rst = 1'b1;
    drive(SymJ, 3);
    check_reset_outputs("reset");
    rst = 1'b0;
    drive(SymJ, 100);
    check("idle_rx_active", rx_active, 0);
    wait_drain("idle_no_pulses");

    // Single byte.
    per_mode = 0;
    pkt[0] = 8'hA5;
    send_packet(1, 0, 1'b0);
    wait_drain("pkt_a5");

    // Stuffing inside 0xFF then 0x00.
    pkt[0] = 8'hFF;
    pkt[1] = 8'h00;
    send_packet(2, 0, 1'b0);
    wait_drain("pkt_ff_00");

    // A 1 in the stuffed slot.
    pkt[0] = 8'hFF;
    pkt[1] = 8'h81;
    send_packet(2, 0, 1'b1);
    wait_drain("pkt_bad_stuff");

    // 3/5 clock jitter.
    per_mode = 1;
    pkt[0] = 8'h3C;
    pkt[1] = 8'hC3;
    send_packet(2, 0, 1'b0);
    wait_drain("pkt_jitter");

    // 12 bits then SE0: byte, partial-byte error, EOP.
    per_mode = 0;
    pkt[0] = 8'($urandom);
    send_packet(1, 4, 1'b0);
    wait_drain("pkt_partial");

    // Reset 4 bits into a packet, then a clean packet.
    send_sync();
    lvl = SymK;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 0) lvl = (lvl == SymK) ? SymJ : SymK;
      bit_time(lvl);
    end
    rst = 1'b1;
    drive(SymJ, 3);
    check_reset_outputs("abort");
    rst = 1'b0;
    drive(SymJ, 20);
    pkt[0] = 8'h5A;
    send_packet(1, 0, 1'b0);
    wait_drain("pkt_after_abort");

    // Lone K: SYNC times out silently.
    bit_time(SymK);
    drive(SymJ, 100);
    check("stray_k_rx_active", rx_active, 0);
    wait_drain("stray_k");

    // Random packets.
    for (int n = 0; n < 12; n++) begin
      per_mode = int'($urandom_range(0, 1));
      nb = int'($urandom_range(1, 4));
      for (int i = 0; i < nb; i++) pkt[i] = 8'($urandom);
      ex = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      bad = (per_mode == 0) && ($urandom_range(0, 3) == 0);
      send_packet(nb, ex, bad);
      wait_drain("pkt_random");
      drive(SymJ, int'($urandom_range(4, 20)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
